// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  localparam int unsigned DEFAULT_TIMEOUT = 64;
  localparam int unsigned TMO_CNT_W       = 8;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; remembers the last side granted.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   take,
  output logic   gnt_valid,
  output grant_e gnt
);

  grant_e last_grant;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    gnt_valid = i_req | d_req;
    gnt       = GNT_I;
    if (i_req && d_req) begin
      if (last_grant == GNT_I) begin
        gnt = GNT_D;
      end else begin
        gnt = GNT_I;
      end
    end else if (d_req) begin
      gnt = GNT_D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_I;
    end else if (take && gnt_valid) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requesters onto one shared memory port.
// Handshake: a requester holds req high until its done pulse; the memory answers a held mem_req with a one-cycle mem_ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          err,
  output arb_state_e    dbg_state
);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT);

  arb_state_e           state;
  grant_e               gnt_q;
  logic [TMO_CNT_W-1:0] tmo_cnt;
  logic                 pick_valid;
  grant_e               pick;

  assign dbg_state = state;

  mem_arb_rr u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .d_req     (d_req),
    .take      (state == ST_IDLE),
    .gnt_valid (pick_valid),
    .gnt       (pick)
  );

  // The mem_* registers double as the latched request: loaded on grant, cleared on leaving MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gnt_q     <= GNT_I;
      tmo_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state   <= ST_MEM;
            gnt_q   <= pick;
            tmo_cnt <= '0;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            if (pick == GNT_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
          end
        end
        ST_MEM: begin
          if (mem_ready || (tmo_cnt == TMO_LIMIT)) begin
            state     <= ST_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= (gnt_q == GNT_I);
            d_done    <= (gnt_q == GNT_D);
            err       <= !mem_ready;
            // A timed-out read leaves the previous read data in place.
            if (mem_ready && !mem_we) begin
              if (gnt_q == GNT_I) begin
                i_rdata <= mem_rdata;
              end else begin
                d_rdata <= mem_rdata;
              end
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          i_done <= 1'b0;
          d_done <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int NREC = 512;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          err;
  arb_state_e    dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model state ----------------
  bit            m_last_d;     // 1 when the data side was served most recently
  logic [DW-1:0] exp_i_rdata;
  logic [DW-1:0] exp_d_rdata;
  logic [DW-1:0] exp_q[$];

  // ---------------- passive monitor ----------------
  int            cyc = 0;
  int            n_txn = 0;
  int            n_done = 0;
  int            bad_cnt = 0;
  int            unstable_cnt = 0;
  logic [AW-1:0] txn_addr[NREC];
  logic          txn_we[NREC];
  logic [DW-1:0] txn_wdata[NREC];
  int            txn_start[NREC];
  logic          done_d[NREC];
  logic          done_err[NREC];
  int            done_cyc[NREC];
  logic          prev_req = 1'b0;
  logic          prev_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (mem_req && !prev_req) begin
        if (n_txn < NREC) begin
          txn_addr[n_txn]  = mem_addr;
          txn_we[n_txn]    = mem_we;
          txn_wdata[n_txn] = mem_wdata;
          txn_start[n_txn] = cyc;
        end
        n_txn++;
      end else if (mem_req && prev_req && n_txn > 0 && n_txn <= NREC) begin
        if (mem_addr !== txn_addr[n_txn-1] || mem_we !== txn_we[n_txn-1] ||
            mem_wdata !== txn_wdata[n_txn-1])
          unstable_cnt++;
      end
      if (i_done || d_done) begin
        if (i_done && d_done) bad_cnt++;
        if (prev_done) bad_cnt++;
        if (n_done < NREC) begin
          done_d[n_done]   = d_done;
          done_err[n_done] = err;
          done_cyc[n_done] = cyc;
        end
        n_done++;
      end
      if (err && !(i_done || d_done)) bad_cnt++;
      if (busy !== (mem_req | i_done | d_done)) bad_cnt++;
      if (!mem_req && (mem_we || mem_addr != '0 || mem_wdata != '0)) bad_cnt++;
    end
    prev_req  = mem_req;
    prev_done = i_done | d_done;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_last_d = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    @(negedge clk);
  endtask

  // Memory responder: answers the next mem_req with mem_ready on its delay-th cycle (0 = never).
  task automatic drive_mem(input int delay, input logic [DW-1:0] rd, input bit drop,
                           output bit got_done);
    int n;
    int guard;
    got_done = 1'b0;
    guard = 0;
    while (mem_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (mem_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL mem_req_wait: mem_req=%b after %0d cycles, required 1", mem_req, guard);
      return;
    end
    n = 1;
    while (n < 40) begin
      if (i_done || d_done) begin
        got_done = 1'b1;
        break;
      end
      mem_ready = (n == delay);
      mem_rdata = (n == delay) ? rd : DW'($urandom);
      @(negedge clk);
      n++;
    end
    mem_ready = 1'b0;
    if (got_done && drop) begin
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL done_wait: no done within %0d cycles of mem_req, required a done pulse", n);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nd;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_rdata, d_rdata, i_done, d_done, mem_req, mem_we, mem_addr, mem_wdata, busy, err} !== '0
        || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: i_rdata=%h d_rdata=%h mem_req=%b busy=%b state=%0d, required all zero/IDLE",
               i_rdata, d_rdata, mem_req, busy, dbg_state);
    end
    apply_reset();
    // A stray mem_ready while idle must be ignored.
    nd = n_done;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (n_done != nd || i_rdata !== '0 || d_rdata !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready_ignored: dones=%0d i_rdata=%h d_rdata=%h busy=%b, required 0/0/0/0",
               n_done - nd, i_rdata, d_rdata, busy);
    end
  endtask

  task automatic test_i_read();
    int nd;
    bit got;
    nd = n_done;
    @(negedge clk);
    i_req = 1'b1;
    i_addr = 32'h40;
    drive_mem(3, 32'h1234_5678, 1'b1, got);
    m_last_d = 1'b0;
    exp_i_rdata = 32'h1234_5678;
    checks++;
    if (n_done != nd + 1 || done_d[nd] !== 1'b0) begin
      errors++;
      $display("FAIL i_read_done: dones=%0d side_d=%b, required 1 I-side done", n_done - nd, done_d[nd]);
    end
    checks++;
    if (txn_addr[n_txn-1] !== 32'h40 || txn_we[n_txn-1] !== 1'b0) begin
      errors++;
      $display("FAIL i_read_req: addr=%h we=%b, required 40/0", txn_addr[n_txn-1], txn_we[n_txn-1]);
    end
    checks++;
    if (done_cyc[nd] - txn_start[n_txn-1] != 3) begin
      errors++;
      $display("FAIL i_read_latency: %0d cycles, required 3", done_cyc[nd] - txn_start[n_txn-1]);
    end
    checks++;
    if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
      errors++;
      $display("FAIL i_read_data: i_rdata=%h d_rdata=%h, required %h/%h", i_rdata, d_rdata,
               exp_i_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_d_write();
    int nd;
    bit got;
    nd = n_done;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h100;
    d_wdata = 32'hCAFE_F00D;
    drive_mem(2, 32'h5555_AAAA, 1'b1, got);
    d_we = 1'b0;
    m_last_d = 1'b1;
    checks++;
    if (txn_we[n_txn-1] !== 1'b1 || txn_addr[n_txn-1] !== 32'h100 ||
        txn_wdata[n_txn-1] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL d_write_req: we=%b addr=%h wdata=%h, required 1/100/cafef00d",
               txn_we[n_txn-1], txn_addr[n_txn-1], txn_wdata[n_txn-1]);
    end
    checks++;
    if (n_done != nd + 1 || done_d[nd] !== 1'b1 || done_err[nd] !== 1'b0) begin
      errors++;
      $display("FAIL d_write_done: dones=%0d side_d=%b err=%b, required 1/1/0", n_done - nd,
               done_d[nd], done_err[nd]);
    end
    checks++;
    if (d_rdata !== exp_d_rdata) begin
      errors++;
      $display("FAIL d_write_rdata_hold: d_rdata=%h, required %h", d_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    bit side;
    int nd;
    logic [DW-1:0] rd;
    logic [AW-1:0] ea;
    apply_reset();
    @(negedge clk);
    i_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    i_addr = 32'h200;
    d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      side = !m_last_d;
      m_last_d = side;
      exp_q.push_back(side ? 32'h300 : 32'h200);
      rd = DW'($urandom);
      nd = n_done;
      drive_mem($urandom_range(1, 4), rd, 1'b0, got);
      if (side) exp_d_rdata = rd;
      else exp_i_rdata = rd;
      ea = exp_q.pop_front();
      checks++;
      if (n_done != nd + 1 || done_d[nd] !== side || txn_addr[n_txn-1] !== ea) begin
        errors++;
        $display("FAIL rr_order[%0d]: side_d=%b addr=%h, required %b/%h", k, done_d[nd],
                 txn_addr[n_txn-1], side, ea);
      end
      checks++;
      if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
        errors++;
        $display("FAIL rr_data[%0d]: i_rdata=%h d_rdata=%h, required %h/%h", k, i_rdata, d_rdata,
                 exp_i_rdata, exp_d_rdata);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle_after: busy=%b mem_req=%b, required 0/0", busy, mem_req);
    end
  endtask

  task automatic test_timeout();
    int nd;
    bit got;
    nd = n_done;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = AW'($urandom);
    drive_mem(0, '0, 1'b1, got);
    m_last_d = 1'b1;
    checks++;
    if (n_done != nd + 1 || done_d[nd] !== 1'b1 || done_err[nd] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: dones=%0d side_d=%b err=%b, required 1/1/1", n_done - nd,
               done_d[nd], done_err[nd]);
    end
    checks++;
    if (done_cyc[nd] - txn_start[n_txn-1] != TMO + 1) begin
      errors++;
      $display("FAIL timeout_latency: %0d cycles, required %0d", done_cyc[nd] - txn_start[n_txn-1],
               TMO + 1);
    end
    checks++;
    if (d_rdata !== exp_d_rdata) begin
      errors++;
      $display("FAIL timeout_rdata_hold: d_rdata=%h, required %h", d_rdata, exp_d_rdata);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: busy=%b state=%0d err=%b, required 0/IDLE/0", busy, dbg_state, err);
    end
  endtask

  task automatic test_addr_hold();
    bit got;
    int us;
    logic [AW-1:0] obs;
    logic [DW-1:0] rd;
    us = unstable_cnt;
    rd = DW'($urandom);
    obs = '0;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10;
    fork
      drive_mem(5, rd, 1'b1, got);
      begin
        repeat (3) @(negedge clk);
        d_addr = 32'h20;
        @(negedge clk);
        obs = mem_addr;
      end
    join
    m_last_d = 1'b1;
    exp_d_rdata = rd;
    checks++;
    if (obs !== 32'h10 || txn_addr[n_txn-1] !== 32'h10 || unstable_cnt != us) begin
      errors++;
      $display("FAIL addr_hold: mem_addr=%h start=%h changes=%0d, required 10/10/0", obs,
               txn_addr[n_txn-1], unstable_cnt - us);
    end
    checks++;
    if (d_rdata !== exp_d_rdata) begin
      errors++;
      $display("FAIL addr_hold_data: d_rdata=%h, required %h", d_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    int guard;
    nd = n_done;
    guard = 0;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = AW'($urandom);
    while (mem_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_async: mem_req=%b busy=%b state=%0d, required 0/0/IDLE", mem_req, busy,
               dbg_state);
    end
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_last_d = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (n_done != nd || d_rdata !== '0 || mem_req !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_late_ready: dones=%0d d_rdata=%h mem_req=%b state=%0d, required 0/0/0/IDLE",
               n_done - nd, d_rdata, mem_req, dbg_state);
    end
  endtask

  task automatic test_random();
    int mode;
    int delay;
    int nd;
    int nt;
    bit pend_i;
    bit pend_d;
    bit side;
    bit got;
    bit exp_err;
    bit exp_we;
    logic [DW-1:0] rd;
    logic [AW-1:0] ea;
    for (int it = 0; it < 25; it++) begin
      @(negedge clk);
      mode = $urandom_range(0, 2);
      pend_i = (mode != 1);
      pend_d = (mode != 0);
      i_addr = AW'($urandom);
      d_addr = AW'($urandom);
      d_we = 1'($urandom);
      d_wdata = DW'($urandom);
      i_req = pend_i;
      d_req = pend_d;
      while (pend_i || pend_d) begin
        side = (pend_i && pend_d) ? !m_last_d : pend_d;
        exp_we = side ? d_we : 1'b0;
        exp_q.push_back(side ? d_addr : i_addr);
        delay = $urandom_range(0, TMO);
        exp_err = (delay == 0);
        rd = DW'($urandom);
        nd = n_done;
        nt = n_txn;
        drive_mem(delay, rd, 1'b1, got);
        m_last_d = side;
        if (side) pend_d = 1'b0;
        else pend_i = 1'b0;
        if (!exp_err && !exp_we) begin
          if (side) exp_d_rdata = rd;
          else exp_i_rdata = rd;
        end
        ea = exp_q.pop_front();
        checks++;
        if (n_done != nd + 1 || n_txn != nt + 1 || done_d[nd] !== side) begin
          errors++;
          $display("FAIL rand_grant[%0d]: dones=%0d txns=%0d side_d=%b, required 1/1/%b", it,
                   n_done - nd, n_txn - nt, done_d[nd], side);
        end
        checks++;
        if (txn_addr[nt] !== ea || txn_we[nt] !== exp_we ||
            (exp_we && txn_wdata[nt] !== d_wdata)) begin
          errors++;
          $display("FAIL rand_req[%0d]: addr=%h we=%b wdata=%h, required %h/%b/%h", it, txn_addr[nt],
                   txn_we[nt], txn_wdata[nt], ea, exp_we, d_wdata);
        end
        checks++;
        if (done_err[nd] !== exp_err ||
            done_cyc[nd] - txn_start[nt] != (exp_err ? TMO + 1 : delay)) begin
          errors++;
          $display("FAIL rand_timing[%0d]: err=%b latency=%0d, required %b/%0d", it, done_err[nd],
                   done_cyc[nd] - txn_start[nt], exp_err, exp_err ? TMO + 1 : delay);
        end
        checks++;
        if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
          errors++;
          $display("FAIL rand_data[%0d]: i_rdata=%h d_rdata=%h, required %h/%h", it, i_rdata, d_rdata,
                   exp_i_rdata, exp_d_rdata);
        end
      end
    end
  endtask

  task automatic test_final();
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL monitor_rules: %0d protocol violations seen, required 0", bad_cnt);
    end
    checks++;
    if (unstable_cnt != 0) begin
      errors++;
      $display("FAIL request_stability: %0d mid-transaction changes, required 0", unstable_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_back_to_back();
    test_timeout();
    test_addr_hold();
    test_reset_mid();
    test_random();
    test_final();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles in MEM state awaiting mem_ready; valid range 2..255.
REQ-004 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_req  input  1  instruction-side read request; held high until i_done.
REQ-007 i_addr  input  AW  instruction-side address.
REQ-008 i_rdata  output  DW  instruction-side read data.
REQ-009 i_done  output  1  single-cycle completion pulse, instruction side.
REQ-010 d_req  input  1  data-side request; held high until d_done.
REQ-011 d_we  input  1  data-side write enable (1 = write, 0 = read).
REQ-012 d_addr  input  AW  data-side address.
REQ-013 d_wdata  input  DW  data-side write data.
REQ-014 d_rdata  output  DW  data-side read data.
REQ-015 d_done  output  1  single-cycle completion pulse, data side.
REQ-016 mem_req  output  1  request to the shared memory.
REQ-017 mem_we  output  1  write strobe to memory.
REQ-018 mem_addr  output  AW  memory address.
REQ-019 mem_wdata  output  DW  memory write data.
REQ-020 mem_rdata  input  DW  memory read data, valid when mem_ready is high.
REQ-021 mem_ready  input  1  memory completion, one cycle.
REQ-022 busy  output  1  high whenever state is not IDLE; drives pipeline stall.
REQ-023 err  output  1  single-cycle pulse, coincident with done, on timeout.

Function
REQ-024 FSM states: IDLE, MEM, RESP; IDLE->MEM when any req is high; MEM->RESP on mem_ready or timeout; RESP->IDLE unconditionally.
REQ-025 In IDLE, a single request is granted; simultaneous i_req and d_req go to the side not granted last (round-robin); last_grant resets to I, so the first tie goes to D.
REQ-026 On grant: address, we (forced 0 for I) and wdata are latched; requester changes afterwards are ignored until done.
REQ-027 mem_req, mem_we, mem_addr and mem_wdata are registered, driven from the latched values in MEM only, and low/zero in IDLE and RESP.
REQ-028 Latency: req high at edge t yields mem_req from t+1; mem_ready sampled at edge t+k (k>=1) yields done high during cycle t+k+1; minimum is done at t+2.
REQ-029 mem_rdata is captured on mem_ready for reads only; i_rdata/d_rdata update only on their own read completion and otherwise hold.
REQ-030 Exactly one of i_done/d_done pulses in RESP, for the granted side only.
REQ-031 The timeout counter clears on MEM entry and increments each MEM cycle without mem_ready; reaching TIMEOUT forces RESP with done=1 and err=1, and rdata holds.
REQ-032 mem_ready in IDLE or RESP is ignored.
REQ-033 Requests are not sampled in RESP; requesters drop req in the done cycle; a req still high in the following IDLE cycle is a new request.
REQ-034 Back-to-back: with both sides requesting continuously, grants alternate D, I, D, ...; neither side starves.

Reset
REQ-035 On rst low, the block immediately enters IDLE and forces all outputs to 0 (rdata=0, done=0, err=0, mem_req=0, busy=0), with last_grant=I and timeout counter=0.
REQ-036 Reset during MEM abandons the transaction with no done pulse; a late mem_ready after reset is ignored.

Structure
REQ-037 Package mem_arb_pkg holds the FSM state enum, the grant encoding (GNT_I, GNT_D) and the default TIMEOUT constant.
REQ-038 One sub-module, mem_arb_rr: the 2-way round-robin picker with the last_grant flop; FSM, latches and counter remain in mem_arbiter.

Verification
REQ-039 I read, i_addr=0x40, mem_ready 3 cycles after mem_req with rdata=0x12345678 -> i_done pulses once; i_rdata=0x12345678; d_done stays 0.
REQ-040 D write, d_addr=0x100, d_wdata=0xCAFEF00D -> mem_we=1 with matching addr/data while in MEM; d_done pulses; d_rdata unchanged.
REQ-041 i_req and d_req rise on the same edge from reset, held through 4 transactions -> grant order D, I, D, I.
REQ-042 D read with mem_ready never asserted, TIMEOUT=8 -> d_done and err pulse together 9 cycles after mem_req rises; busy then drops.
REQ-043 rst pulled low 2 cycles into MEM, mem_ready arrives after release -> no done pulse; mem_req drops asynchronously; state IDLE.
REQ-044 d_addr changed from 0x10 to 0x20 during MEM -> mem_addr stays 0x10 until done.
